issue_scheduler: RTL and testbench
==================================

Name: issue_scheduler

Overview:
Unified issue queue and select logic between rename_stage and the functional units. It holds renamed instructions until every valid source PRN is ready, tracking readiness from FU ready-PRN broadcasts. Each cycle it picks the oldest ready entry for each FU and drives that FU's PRF read request and issue bundle. It also provides back-pressure to the renamer and empties on a pipeline flush.

Parameters:
ENTRIES, 8, number of queue entries (power of two, 2..32)
FU_COUNT, 4, functional units / issue ports
MAX_OPERANDS, 3, source/destination PRN slots per instruction
PRN_BITS, 6, physical register number width
INST_ID_BITS, 6, ROB instruction id width
FUC_BITS, 2, FU selector width ($clog2(FU_COUNT))

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
in_valid  in  1  renamer offers an instruction
in_ready  out  1  a free entry exists
in_inst_id  in  INST_ID_BITS  ROB id
in_raw_instr  in  32  instruction word
in_instr_pc  in  64  instruction PC
in_fu_choice  in  FUC_BITS  target FU
in_prn_input_valid  in  [MAX_OPERANDS] x 1  source slot used
in_prn_input_ready  in  [MAX_OPERANDS] x 1  source already ready at rename
in_prn_input  in  [MAX_OPERANDS] x PRN_BITS  source PRNs
in_prn_output_valid  in  [MAX_OPERANDS] x 1  destination slot used
in_prn_output  in  [MAX_OPERANDS] x PRN_BITS  destination PRNs
wake_valid  in  [FU_COUNT][MAX_OPERANDS] x 1  ready-PRN broadcast valid
wake_prn  in  [FU_COUNT][MAX_OPERANDS] x PRN_BITS  PRN becoming ready
fu_ready  in  [FU_COUNT] x 1  FU can accept an issue this cycle
flush  in  1  discard all entries
issue_valid  out  [FU_COUNT] x 1  issue bundle valid (one-cycle pulse)
issue_inst_id  out  [FU_COUNT] x INST_ID_BITS  issued ROB id
issue_raw_instr  out  [FU_COUNT] x 32  issued instruction
issue_instr_pc  out  [FU_COUNT] x 64  issued PC
issue_prn_output_valid  out  [FU_COUNT][MAX_OPERANDS] x 1  destination valid
issue_prn_output  out  [FU_COUNT][MAX_OPERANDS] x PRN_BITS  destination PRNs
prf_ren  out  [MAX_OPERANDS][FU_COUNT] x 1  PRF read enables (matches prf port order)
prf_rprn  out  [MAX_OPERANDS][FU_COUNT] x PRN_BITS  PRF read addresses
occupancy  out  $clog2(ENTRIES)+1  number of valid entries

Behaviour:
- Reset (rst low, async): all entries invalid, age matrix cleared, issue_valid/prf_ren all 0, all other issue/prf outputs 0, occupancy 0. in_ready=1 as soon as rst deasserts.
- Entry state: valid, fu_choice, inst_id, instr, pc, per-slot src {valid, ready, prn}, per-slot dst {valid, prn}. Invalid source slots count as ready.
- in_ready is derived only from registered valid bits (any free entry). It does not account for same-cycle issue, so there is no comb path from fu_ready to in_ready.
- Enqueue: in_valid && in_ready && !flush writes the lowest-index free entry at the edge. src ready = in_prn_input_ready OR a match against this cycle's wake bus (same-cycle bypass, so no wakeup is lost).
- Wakeup: for each valid, not-ready source, a match of wake_prn with wake_valid in any [f][k] sets ready at the next edge. A woken entry becomes eligible one cycle after the broadcast.
- Eligibility: valid, all sources ready, fu_choice==f, fu_ready[f].
- Select: per FU, the oldest eligible entry. Age is an ENTRIES x ENTRIES matrix; older[i][j] is set on enqueue of j for every currently valid i. An entry can match at most one FU, so there are no cross-FU conflicts.
- Issue latency 1: the selected entry is freed at edge N. At edge N, issue_* and prf_ren/prf_rprn register the entry's fields, so they are visible in cycle N+1 for exactly one cycle. prf_ren[k][f] = src valid[k] of the issued entry; prf_rprn[k][f] = its src prn[k]. With no selection, issue_valid[f]=0 and prf_ren[*][f]=0.
- Simultaneous enqueue and issue in one cycle: both take effect. A freed entry is reusable from the next cycle. occupancy = prev + enq − number issued.
- Full (occupancy==ENTRIES): in_ready=0. Renamer input is ignored even if in_valid.
- Flush: at the edge, all entries invalidated, issue_valid and prf_ren cleared, occupancy 0. Flush overrides a same-cycle enqueue and select.
- rst asserted mid-operation: immediate clear, identical to reset.

Decomposition:
- Package foxtrot_pkg: MAX_OPERANDS, FU_COUNT, FUC_BITS, PRN_BITS, INST_ID_BITS, and the typedef iq_entry_t (entry fields above).
- One sub-module, iq_oldest_select: combinational; given an eligibility vector and the age matrix, returns one-hot oldest plus valid. Instantiated FU_COUNT times.

Test Plan:
- Reset then enqueue id=5, fu=1, srcs {p3 ready, p7 ready, unused}, fu_ready=1111 -> one cycle later issue_valid=0010, issue_inst_id[1]=5, prf_ren[0][1]=prf_ren[1][1]=1, prf_rprn=3,7, prf_ren[2][1]=0; occupancy 1->0.
- Enqueue id=2 with src p9 not ready; wake_prn[3][0]=9 two cycles later -> issue_valid[fu] high exactly 2 cycles after the wake (1 cycle to ready, 1 cycle to issue).
- Enqueue id=4 with src p12 not ready while wake p12 is asserted in the same cycle -> entry is ready immediately; issues one cycle after enqueue.
- Enqueue ids 10, 11, 12 (all ready, fu=0) with fu_ready[0]=0, then raise fu_ready[0] -> issues in order 10, 11, 12 on consecutive cycles.
- Fill 8 entries with non-ready sources -> in_ready=0, occupancy=8. A 9th in_valid is dropped. Wake one entry -> in_ready returns to 1 the cycle after it issues.
- With 5 entries valid, assert flush together with in_valid -> next cycle occupancy=0, no issue_valid, enqueued instruction absent.

Source files
------------

// File: rtl/foxtrot_pkg.sv
// Shared widths, entry layout and wake-bus helper for the unified issue queue.
package foxtrot_pkg;

    localparam int MAX_OPERANDS = 3;
    localparam int FU_COUNT     = 4;
    localparam int FUC_BITS     = 2;
    localparam int PRN_BITS     = 6;
    localparam int INST_ID_BITS = 6;

    typedef logic [PRN_BITS-1:0]                                  prn_t;
    typedef logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]                wake_valid_t;
    typedef logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0]  wake_prn_t;

    typedef struct packed {
        logic                                   valid;
        logic [FUC_BITS-1:0]                    fu_choice;
        logic [INST_ID_BITS-1:0]                inst_id;
        logic [31:0]                            instr;
        logic [63:0]                            pc;
        logic [MAX_OPERANDS-1:0]                src_valid;
        logic [MAX_OPERANDS-1:0]                src_ready;
        logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  src_prn;
        logic [MAX_OPERANDS-1:0]                dst_valid;
        logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  dst_prn;
    } iq_entry_t;

    // True when any lane of the ready-PRN broadcast names this register.
    function automatic logic wake_hit(input prn_t prn, input wake_valid_t wv, input wake_prn_t wp);
        logic hit;
        hit = 1'b0;
        for (int f = 0; f < FU_COUNT; f++)
            for (int k = 0; k < MAX_OPERANDS; k++)
                hit = hit | (wv[f][k] && (wp[f][k] == prn));
        return hit;
    endfunction

endpackage

// File: rtl/issue_scheduler_if.sv
// Rename-in, wakeup, FU-issue and PRF-read signals of the issue scheduler.
interface issue_scheduler_if #(parameter int ENTRIES = 8);
    import foxtrot_pkg::*;

    localparam int OCC_BITS = $clog2(ENTRIES) + 1;

    logic                                                in_valid;
    logic                                                in_ready;
    logic [INST_ID_BITS-1:0]                             in_inst_id;
    logic [31:0]                                         in_raw_instr;
    logic [63:0]                                         in_instr_pc;
    logic [FUC_BITS-1:0]                                 in_fu_choice;
    logic [MAX_OPERANDS-1:0]                             in_prn_input_valid;
    logic [MAX_OPERANDS-1:0]                             in_prn_input_ready;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]               in_prn_input;
    logic [MAX_OPERANDS-1:0]                             in_prn_output_valid;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]               in_prn_output;
    wake_valid_t                                         wake_valid;
    wake_prn_t                                           wake_prn;
    logic [FU_COUNT-1:0]                                 fu_ready;
    logic                                                flush;
    logic [FU_COUNT-1:0]                                 issue_valid;
    logic [FU_COUNT-1:0][INST_ID_BITS-1:0]               issue_inst_id;
    logic [FU_COUNT-1:0][31:0]                           issue_raw_instr;
    logic [FU_COUNT-1:0][63:0]                           issue_instr_pc;
    logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]               issue_prn_output_valid;
    logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] issue_prn_output;
    logic [MAX_OPERANDS-1:0][FU_COUNT-1:0]               prf_ren;
    logic [MAX_OPERANDS-1:0][FU_COUNT-1:0][PRN_BITS-1:0] prf_rprn;
    logic [OCC_BITS-1:0]                                 occupancy;

    modport master (
        output in_valid, in_inst_id, in_raw_instr, in_instr_pc, in_fu_choice,
               in_prn_input_valid, in_prn_input_ready, in_prn_input,
               in_prn_output_valid, in_prn_output, wake_valid, wake_prn, fu_ready, flush,
        input  in_ready, issue_valid, issue_inst_id, issue_raw_instr, issue_instr_pc,
               issue_prn_output_valid, issue_prn_output, prf_ren, prf_rprn, occupancy
    );

    modport slave (
        input  in_valid, in_inst_id, in_raw_instr, in_instr_pc, in_fu_choice,
               in_prn_input_valid, in_prn_input_ready, in_prn_input,
               in_prn_output_valid, in_prn_output, wake_valid, wake_prn, fu_ready, flush,
        output in_ready, issue_valid, issue_inst_id, issue_raw_instr, issue_instr_pc,
               issue_prn_output_valid, issue_prn_output, prf_ren, prf_rprn, occupancy
    );

endinterface

// File: rtl/iq_oldest_select.sv
// Picks the oldest eligible entry: one that no other eligible entry is older than.
module iq_oldest_select #(
    parameter int ENTRIES = 8
) (
    input  logic [ENTRIES-1:0]              elig,
    input  logic [ENTRIES-1:0][ENTRIES-1:0] older,   // older[i][j]: i is older than j
    output logic [ENTRIES-1:0]              grant,
    output logic                            grant_valid
);

    logic blocked;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned and infers a latch.
    always_comb begin
        grant   = '0;
        blocked = 1'b0;
        for (int j = 0; j < ENTRIES; j++) begin
            blocked = 1'b0;
            for (int i = 0; i < ENTRIES; i++)
                blocked = blocked | (elig[i] & older[i][j]);
            grant[j] = elig[j] & ~blocked;
        end
    end

    assign grant_valid = |elig;

endmodule

// File: rtl/issue_scheduler.sv
// Unified issue queue: holds renamed instructions until sources are ready, issues oldest-first per FU.
module issue_scheduler
    import foxtrot_pkg::*;
#(
    parameter int ENTRIES = 8
) (
    input  logic            clk,
    input  logic            rst,
    issue_scheduler_if.slave bus
);

    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam int OCC_BITS = $clog2(ENTRIES) + 1;

    iq_entry_t                          entries [ENTRIES];
    iq_entry_t                          enq_entry;
    logic [ENTRIES-1:0][ENTRIES-1:0]    older;
    logic [ENTRIES-1:0]                 valid_vec;
    logic [IDX_BITS-1:0]                free_idx;
    logic                               enq;
    logic [FU_COUNT-1:0][ENTRIES-1:0]   elig;
    logic [FU_COUNT-1:0][ENTRIES-1:0]   grant;
    logic [FU_COUNT-1:0]                grant_valid;
    logic [FU_COUNT-1:0][IDX_BITS-1:0]  sel_idx;
    logic [ENTRIES-1:0]                 issued;
    logic [OCC_BITS-1:0]                occ;

    logic [FU_COUNT-1:0]                                 issue_valid_q;
    logic [FU_COUNT-1:0][INST_ID_BITS-1:0]               inst_id_q;
    logic [FU_COUNT-1:0][31:0]                           instr_q;
    logic [FU_COUNT-1:0][63:0]                           pc_q;
    logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]               dst_valid_q;
    logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] dst_prn_q;
    logic [MAX_OPERANDS-1:0][FU_COUNT-1:0]               prf_ren_q;
    logic [MAX_OPERANDS-1:0][FU_COUNT-1:0][PRN_BITS-1:0] prf_rprn_q;

    always_comb begin
        valid_vec = '0;
        free_idx  = '0;
        occ       = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            valid_vec[i] = entries[i].valid;
            occ          = occ + OCC_BITS'(entries[i].valid);
        end
        for (int i = ENTRIES - 1; i >= 0; i--)
            if (!entries[i].valid) free_idx = IDX_BITS'(i);
    end

    // Back-pressure looks only at registered valids, keeping fu_ready off this path.
    assign bus.in_ready = ~&valid_vec;
    assign enq          = bus.in_valid & bus.in_ready & ~bus.flush;

    always_comb begin
        enq_entry           = '0;
        enq_entry.valid     = 1'b1;
        enq_entry.fu_choice = bus.in_fu_choice;
        enq_entry.inst_id   = bus.in_inst_id;
        enq_entry.instr     = bus.in_raw_instr;
        enq_entry.pc        = bus.in_instr_pc;
        enq_entry.src_valid = bus.in_prn_input_valid;
        enq_entry.src_prn   = bus.in_prn_input;
        enq_entry.dst_valid = bus.in_prn_output_valid;
        enq_entry.dst_prn   = bus.in_prn_output;
        for (int k = 0; k < MAX_OPERANDS; k++)
            enq_entry.src_ready[k] = bus.in_prn_input_ready[k]
                                   | wake_hit(bus.in_prn_input[k], bus.wake_valid, bus.wake_prn);
    end

    always_comb begin
        elig = '0;
        for (int f = 0; f < FU_COUNT; f++)
            for (int i = 0; i < ENTRIES; i++)
                elig[f][i] = entries[i].valid
                           && (&(entries[i].src_ready | ~entries[i].src_valid))
                           && (entries[i].fu_choice == FUC_BITS'(f))
                           && bus.fu_ready[f];
    end

    for (genvar f = 0; f < FU_COUNT; f++) begin : g_sel
        iq_oldest_select #(.ENTRIES(ENTRIES)) u_sel (
            .elig        (elig[f]),
            .older       (older),
            .grant       (grant[f]),
            .grant_valid (grant_valid[f])
        );
    end

    always_comb begin
        sel_idx = '0;
        issued  = '0;
        for (int f = 0; f < FU_COUNT; f++) begin
            for (int i = 0; i < ENTRIES; i++)
                if (grant[f][i]) sel_idx[f] = IDX_BITS'(i);
            issued = issued | grant[f];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the payload array is reset along with valid bits; it is small and keeps X off the issue bundle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) entries[i] <= '0;
            older <= '0;
        end else if (bus.flush) begin
            for (int i = 0; i < ENTRIES; i++) entries[i].valid <= 1'b0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (issued[i]) begin
                    entries[i].valid <= 1'b0;
                end else if (entries[i].valid) begin
                    for (int k = 0; k < MAX_OPERANDS; k++)
                        if (wake_hit(entries[i].src_prn[k], bus.wake_valid, bus.wake_prn))
                            entries[i].src_ready[k] <= 1'b1;
                end
            end
            if (enq) begin
                entries[free_idx] <= enq_entry;
                older[free_idx]   <= '0;
                for (int i = 0; i < ENTRIES; i++) older[i][free_idx] <= valid_vec[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_valid_q <= '0;
            inst_id_q     <= '0;
            instr_q       <= '0;
            pc_q          <= '0;
            dst_valid_q   <= '0;
            dst_prn_q     <= '0;
            prf_ren_q     <= '0;
            prf_rprn_q    <= '0;
        end else begin
            for (int f = 0; f < FU_COUNT; f++) begin
                if (!bus.flush && grant_valid[f]) begin
                    issue_valid_q[f] <= 1'b1;
                    inst_id_q[f]     <= entries[sel_idx[f]].inst_id;
                    instr_q[f]       <= entries[sel_idx[f]].instr;
                    pc_q[f]          <= entries[sel_idx[f]].pc;
                    dst_valid_q[f]   <= entries[sel_idx[f]].dst_valid;
                    dst_prn_q[f]     <= entries[sel_idx[f]].dst_prn;
                    for (int k = 0; k < MAX_OPERANDS; k++) begin
                        prf_ren_q[k][f]  <= entries[sel_idx[f]].src_valid[k];
                        prf_rprn_q[k][f] <= entries[sel_idx[f]].src_prn[k];
                    end
                end else begin
                    issue_valid_q[f] <= 1'b0;
                    inst_id_q[f]     <= '0;
                    instr_q[f]       <= '0;
                    pc_q[f]          <= '0;
                    dst_valid_q[f]   <= '0;
                    dst_prn_q[f]     <= '0;
                    for (int k = 0; k < MAX_OPERANDS; k++) begin
                        prf_ren_q[k][f]  <= 1'b0;
                        prf_rprn_q[k][f] <= '0;
                    end
                end
            end
        end
    end

    assign bus.issue_valid            = issue_valid_q;
    assign bus.issue_inst_id          = inst_id_q;
    assign bus.issue_raw_instr        = instr_q;
    assign bus.issue_instr_pc         = pc_q;
    assign bus.issue_prn_output_valid = dst_valid_q;
    assign bus.issue_prn_output       = dst_prn_q;
    assign bus.prf_ren                = prf_ren_q;
    assign bus.prf_rprn               = prf_rprn_q;
    assign bus.occupancy              = occ;

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed checks of enqueue, wakeup, oldest-first select, back-pressure, flush and reset.
module tb_issue_scheduler;
    import foxtrot_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    issue_scheduler_if #(.ENTRIES(8)) bus ();
    issue_scheduler #(.ENTRIES(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.in_valid            = 1'b0;
        bus.in_inst_id          = '0;
        bus.in_raw_instr        = '0;
        bus.in_instr_pc         = '0;
        bus.in_fu_choice        = '0;
        bus.in_prn_input_valid  = '0;
        bus.in_prn_input_ready  = '0;
        bus.in_prn_input        = '0;
        bus.in_prn_output_valid = '0;
        bus.in_prn_output       = '0;
        bus.wake_valid          = '0;
        bus.wake_prn            = '0;
        bus.flush               = 1'b0;
    endtask

    // Offer one instruction with a single source slot 0 (or none when srcv==0).
    task automatic offer(input int id, input int fu, input logic srcv, input logic srcr, input int prn);
        bus.in_valid              = 1'b1;
        bus.in_inst_id            = INST_ID_BITS'(id);
        bus.in_raw_instr          = 32'h1000 + 32'(id);
        bus.in_instr_pc           = 64'h8000 + 64'(id);
        bus.in_fu_choice          = FUC_BITS'(fu);
        bus.in_prn_input_valid    = '0;
        bus.in_prn_input_ready    = '0;
        bus.in_prn_input          = '0;
        bus.in_prn_input_valid[0] = srcv;
        bus.in_prn_input_ready[0] = srcr;
        bus.in_prn_input[0]       = PRN_BITS'(prn);
    endtask

    initial begin
        clear_inputs();
        bus.fu_ready = 4'b1111;

        #12;
        check("reset_occupancy", 64'(bus.occupancy), 64'd0);
        check("reset_issue_valid", 64'(bus.issue_valid), 64'd0);
        check("reset_prf_ren", 64'(bus.prf_ren), 64'd0);
        rst = 1'b1;
        #1;
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);

        // Basic: two ready sources, issue one cycle after enqueue.
        offer(5, 1, 1'b1, 1'b1, 3);
        bus.in_prn_input_valid[1]  = 1'b1;
        bus.in_prn_input_ready[1]  = 1'b1;
        bus.in_prn_input[1]        = 6'd7;
        bus.in_prn_output_valid[0] = 1'b1;
        bus.in_prn_output[0]       = 6'd20;
        tick();
        clear_inputs();
        check("t1_occ_after_enq", 64'(bus.occupancy), 64'd1);
        check("t1_no_issue_yet", 64'(bus.issue_valid), 64'd0);
        tick();
        check("t1_issue_valid", 64'(bus.issue_valid), 64'b0010);
        check("t1_inst_id", 64'(bus.issue_inst_id[1]), 64'd5);
        check("t1_raw_instr", 64'(bus.issue_raw_instr[1]), 64'h1005);
        check("t1_pc", 64'(bus.issue_instr_pc[1]), 64'h8005);
        check("t1_prf_ren", 64'(bus.prf_ren), 64'h022);
        check("t1_prf_rprn0", 64'(bus.prf_rprn[0][1]), 64'd3);
        check("t1_prf_rprn1", 64'(bus.prf_rprn[1][1]), 64'd7);
        check("t1_dst_valid", 64'(bus.issue_prn_output_valid[1]), 64'b001);
        check("t1_dst_prn", 64'(bus.issue_prn_output[1][0]), 64'd20);
        check("t1_occ_after_issue", 64'(bus.occupancy), 64'd0);
        tick();
        check("t1_pulse_one_cycle", 64'(bus.issue_valid), 64'd0);

        // Wakeup: ready one edge after the broadcast, issue one edge later.
        offer(2, 2, 1'b1, 1'b0, 9);
        tick();
        clear_inputs();
        tick();
        check("t2_waiting", 64'(bus.issue_valid), 64'd0);
        bus.wake_valid[3][0] = 1'b1;
        bus.wake_prn[3][0]   = 6'd9;
        tick();
        clear_inputs();
        check("t2_one_after_wake", 64'(bus.issue_valid), 64'd0);
        tick();
        check("t2_two_after_wake", 64'(bus.issue_valid), 64'b0100);
        check("t2_inst_id", 64'(bus.issue_inst_id[2]), 64'd2);

        // Same-cycle wake bypass at enqueue.
        offer(4, 3, 1'b1, 1'b0, 12);
        bus.wake_valid[0][1] = 1'b1;
        bus.wake_prn[0][1]   = 6'd12;
        tick();
        clear_inputs();
        check("t3_enq_no_issue", 64'(bus.issue_valid), 64'd0);
        tick();
        check("t3_bypass_issue", 64'(bus.issue_valid), 64'b1000);
        check("t3_inst_id", 64'(bus.issue_inst_id[3]), 64'd4);

        // Oldest-first on one FU once it becomes ready.
        bus.fu_ready = 4'b1110;
        for (int n = 10; n <= 12; n++) begin
            offer(n, 0, 1'b0, 1'b0, 0);
            tick();
        end
        clear_inputs();
        check("t4_occ_held", 64'(bus.occupancy), 64'd3);
        check("t4_held_no_issue", 64'(bus.issue_valid), 64'd0);
        bus.fu_ready = 4'b1111;
        for (int n = 10; n <= 12; n++) begin
            tick();
            check("t4_order_valid", 64'(bus.issue_valid), 64'b0001);
            check("t4_order_id", 64'(bus.issue_inst_id[0]), 64'(n));
        end
        check("t4_drained", 64'(bus.occupancy), 64'd0);

        // Fill to capacity; a ninth offer is dropped.
        for (int n = 0; n < 8; n++) begin
            offer(20 + n, 0, 1'b1, 1'b0, 30 + n);
            tick();
        end
        check("t5_full_occ", 64'(bus.occupancy), 64'd8);
        check("t5_full_in_ready", 64'(bus.in_ready), 64'd0);
        offer(40, 1, 1'b0, 1'b0, 0);
        tick();
        clear_inputs();
        check("t5_drop_occ", 64'(bus.occupancy), 64'd8);
        tick();
        check("t5_dropped_not_issued", 64'(bus.issue_valid), 64'd0);
        bus.wake_valid[2][2] = 1'b1;
        bus.wake_prn[2][2]   = 6'd30;
        tick();
        clear_inputs();
        check("t5_still_full", 64'(bus.in_ready), 64'd0);
        tick();
        check("t5_issue_valid", 64'(bus.issue_valid), 64'b0001);
        check("t5_issue_id", 64'(bus.issue_inst_id[0]), 64'd20);
        check("t5_in_ready_back", 64'(bus.in_ready), 64'd1);
        check("t5_occ_7", 64'(bus.occupancy), 64'd7);

        // Two wakes at once on one FU: older (21) goes first.
        bus.wake_valid[0][0] = 1'b1;
        bus.wake_prn[0][0]   = 6'd32;
        bus.wake_valid[1][0] = 1'b1;
        bus.wake_prn[1][0]   = 6'd31;
        tick();
        clear_inputs();
        tick();
        check("t6_first_id", 64'(bus.issue_inst_id[0]), 64'd21);
        tick();
        check("t6_second_id", 64'(bus.issue_inst_id[0]), 64'd22);
        check("t6_occ_5", 64'(bus.occupancy), 64'd5);

        // Flush beats a same-cycle enqueue.
        offer(50, 1, 1'b0, 1'b0, 0);
        bus.flush = 1'b1;
        tick();
        clear_inputs();
        check("t6_flush_occ", 64'(bus.occupancy), 64'd0);
        check("t6_flush_issue", 64'(bus.issue_valid), 64'd0);
        check("t6_flush_prf_ren", 64'(bus.prf_ren), 64'd0);
        tick();
        check("t6_flushed_enq_absent", 64'(bus.issue_valid), 64'd0);
        check("t6_flushed_occ", 64'(bus.occupancy), 64'd0);

        // Asynchronous reset mid-operation.
        offer(7, 0, 1'b1, 1'b0, 5);
        tick();
        clear_inputs();
        check("t7_occ_before_rst", 64'(bus.occupancy), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("t7_async_rst_occ", 64'(bus.occupancy), 64'd0);
        rst = 1'b1;
        tick();
        check("t7_post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("t7_post_rst_issue", 64'(bus.issue_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
